// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier.
package seq_mult_pkg;

  // Controller states; the encodings are fixed so other blocks and
  // debug tooling can decode the state register directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/parametric_RCA.sv
// Parametric ripple-carry adder: s = a + b + ci, with carry-out co.
module parametric_RCA #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic            co
);

  // Ripple the carry from bit 0 upward, one full adder per bit.
  always_comb begin
    logic c;
    // NOTE: combinational blocks use blocking '=' so the carry ripples in
    // order, and every output gets a default first so no latch is inferred.
    s = '0;
    c = ci;
    for (int i = 0; i < SIZE; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned SIZE x SIZE shift-add multiplier, one add/shift per clock.
// A request is taken in IDLE, runs SIZE iterations in CALC and presents
// the product with a one-cycle done pulse in DONE.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int CW = $clog2(SIZE + 1);

  state_t          state;
  logic [SIZE-1:0] mcand;
  logic [SIZE-1:0] mreg;
  logic [SIZE:0]   acc;
  logic [CW-1:0]   cnt;

  logic [SIZE-1:0] addend;
  logic [SIZE-1:0] sum;
  logic            cout;
  logic [SIZE:0]   acc_next;
  logic [SIZE-1:0] mreg_next;

  // Partial product for this iteration: the multiplicand or zero.
  assign addend = mreg[0] ? mcand : '0;

  parametric_RCA #(
    .SIZE(SIZE)
  ) u_rca (
    .a (acc[SIZE-1:0]),
    .b (addend),
    .ci(1'b0),
    .s (sum),
    .co(cout)
  );

  // {cout, sum, mreg} shifted right by one lands in {acc, mreg}.
  assign acc_next  = {1'b0, cout, sum[SIZE-1:1]};
  assign mreg_next = {sum[0], mreg[SIZE-1:1]};

  // Controller and datapath registers, with registered busy/done/product.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here, operands included, is cleared by reset so
    // an aborted operation leaves no stale state; there is no memory array.
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples the pre-edge values, matching the hardware flops.
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mreg  <= b;
            acc   <= '0;
            cnt   <= CW'(SIZE);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          mreg <= mreg_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product <= {acc_next[SIZE-1:0], mreg_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The shift always vacates the accumulator carry slot before the next add.
  always_ff @(posedge clk) begin
    if (!rst) assert (!acc[SIZE]);
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: SIZE=4 and SIZE=8 instances against an arithmetic
// reference (a*b, latency SIZE) with directed and random operands.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [7:0] p4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  int     n_vec = 0;
  int     n_err = 0;
  longint prev_p[2];

  always #5 clk = ~clk;

  seq_multiplier #(.SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(p4)
  );

  seq_multiplier #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic bit get_busy(input int sel);
    return (sel == 0) ? busy4 : busy8;
  endfunction

  function automatic bit get_done(input int sel);
    return (sel == 0) ? done4 : done8;
  endfunction

  function automatic longint get_prod(input int sel);
    return (sel == 0) ? longint'(p4) : longint'(p8);
  endfunction

  task automatic drive(input int sel, input bit st, input int av, input int bv);
    if (sel == 0) begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0];
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  // One multiply: request at a negedge, accept on the next rising edge,
  // then a2/b2 are driven (start held if 'hold') until done is seen.
  task automatic do_op(input int sel, input int av, input int bv,
                       input bit hold, input int a2, input int b2,
                       input string tag);
    int     w        = width_of(sel);
    longint exp      = longint'(av) * longint'(bv);
    int     busy_cnt = 0;
    bit     seen     = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    @(negedge clk);
    check({tag, " product held at accept"}, get_prod(sel), prev_p[sel]);
    if (get_busy(sel)) busy_cnt++;
    drive(sel, hold, a2, b2);
    for (int n = 2; n <= w + 4 && !seen; n++) begin
      @(negedge clk);
      if (get_busy(sel)) busy_cnt++;
      if (get_done(sel)) begin
        seen = 1'b1;
        check({tag, " latency"}, n, w + 1);
        drive(sel, 1'b0, a2, b2);
      end
    end
    if (!seen) begin
      check({tag, " done timeout"}, 0, 1);
      drive(sel, 1'b0, a2, b2);
    end
    check({tag, " busy cycles"}, busy_cnt, w);
    check({tag, " product"}, get_prod(sel), exp);
    prev_p[sel] = exp;
    @(negedge clk);
    check({tag, " done one cycle"}, get_done(sel), 0);
    check({tag, " idle after done"}, get_busy(sel), 0);
  endtask

  initial begin
    int m;
    prev_p[0] = 0;
    prev_p[1] = 0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset product4", p4, 0);
    check("reset product8", p8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed SIZE=4 cases.
    do_op(0, 3, 5, 1'b0, 3, 5, "3x5");
    do_op(0, 15, 15, 1'b0, 0, 0, "15x15");
    do_op(0, 0, 9, 1'b0, 15, 15, "0x9");
    do_op(0, 9, 0, 1'b0, 15, 15, "9x0");
    do_op(0, 7, 6, 1'b1, 2, 2, "7x6 start held");

    // Reset in the middle of iteration 2 of 13x11.
    @(negedge clk);
    drive(0, 1'b1, 13, 11);
    @(negedge clk);
    drive(0, 1'b0, 13, 11);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-calc reset busy", busy4, 0);
    check("mid-calc reset done", done4, 0);
    check("mid-calc reset product", p4, 0);
    prev_p[0] = 0;
    prev_p[1] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      check("no done after abort", done4, 0);
    end
    do_op(0, 13, 11, 1'b0, 1, 1, "13x11 after reset");

    // Directed SIZE=8 corner.
    do_op(1, 255, 255, 1'b0, 0, 0, "255x255");
    do_op(1, 1, 128, 1'b0, 255, 255, "1x128");

    // Random sweeps on both widths.
    for (int i = 0; i < 12; i++) begin
      m = (1 << width_of(0)) - 1;
      do_op(0, int'($urandom_range(0, m)), int'($urandom_range(0, m)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, m)),
            int'($urandom_range(0, m)), "rand4");
    end
    for (int i = 0; i < 12; i++) begin
      m = (1 << width_of(1)) - 1;
      do_op(1, int'($urandom_range(0, m)), int'($urandom_range(0, m)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, m)),
            int'($urandom_range(0, m)), "rand8");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
